// File: rtl/data_unpack_if.sv
// H2C stream and unpacked-frame consumer bundle for data_unpack.
// The slave modport is the unpacker's view; the master modport drives it.
interface data_unpack_if #(
    parameter int TDATA_W = 512
);
    logic [TDATA_W-1:0] s_axis_h2c_tdata;
    logic               s_axis_h2c_tvalid;
    logic               s_axis_h2c_tlast;
    logic               s_axis_h2c_tready;
    logic [4063:0]      in_io_data;
    logic               data_valid;
    logic               data_taken;
    logic [7:0]         data_num_wire;
    logic               seq_err;
    logic               len_err;

    modport slave (
        input  s_axis_h2c_tdata,
        input  s_axis_h2c_tvalid,
        input  s_axis_h2c_tlast,
        output s_axis_h2c_tready,
        output in_io_data,
        output data_valid,
        input  data_taken,
        output data_num_wire,
        output seq_err,
        output len_err
    );

    modport master (
        output s_axis_h2c_tdata,
        output s_axis_h2c_tvalid,
        output s_axis_h2c_tlast,
        input  s_axis_h2c_tready,
        input  in_io_data,
        input  data_valid,
        output data_taken,
        input  data_num_wire,
        input  seq_err,
        input  len_err
    );
endinterface

// File: rtl/data_unpack.sv
// Reassembles 4096-bit frames from an H2C beat stream and presents the payload until taken.
// Optional sequence-number checking is enabled with `define DATA_UNPACK_SEQ_CHECK_EN.
module data_unpack #(
    parameter int TDATA_W = 512
) (
    input  logic          s_axis_h2c_aclk,
    input  logic          s_axis_h2c_aresetn,
    input  logic          en,
    data_unpack_if.slave  bus
);
    localparam int FRAME_BEATS = (4096 + TDATA_W - 1) / TDATA_W;
    localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int BUF_W       = (FRAME_BEATS - 1) * TDATA_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [BUF_W-1:0]  r_buf;
    logic              r_tready;
    logic              r_data_valid;
    logic [4063:0]     r_in_io_data;
    logic [7:0]        r_data_num;
    logic              r_len_err;

    logic              w_hs;
    logic [4095:0]     w_frame;
    logic [7:0]        w_seq;
    logic              w_unused_hi;

    // The final beat is merged combinationally so the payload registers on the same edge.
    assign w_frame     = {bus.s_axis_h2c_tdata, r_buf};
    assign w_seq       = w_frame[7:0];
    assign w_hs        = bus.s_axis_h2c_tvalid && r_tready;
    assign w_unused_hi = ^w_frame[4095:4072];

`ifdef DATA_UNPACK_SEQ_CHECK_EN
    logic r_seq_err;
    assign bus.seq_err = r_seq_err;
`else
    assign bus.seq_err = 1'b0;
`endif

    assign bus.s_axis_h2c_tready = r_tready;
    assign bus.data_valid        = r_data_valid;
    assign bus.in_io_data        = r_in_io_data;
    assign bus.data_num_wire     = r_data_num;
    assign bus.len_err           = r_len_err;

    // Frame collection FSM with registered handshake, payload and status outputs.
    always_ff @(posedge s_axis_h2c_aclk or negedge s_axis_h2c_aresetn) begin
        if (!s_axis_h2c_aresetn) begin
            r_state      <= ST_COLLECT;
            r_beat_cnt   <= '0;
            r_buf        <= '0;
            r_tready     <= 1'b0;
            r_data_valid <= 1'b0;
            r_in_io_data <= '0;
            r_data_num   <= 8'd0;
            r_len_err    <= 1'b0;
`ifdef DATA_UNPACK_SEQ_CHECK_EN
            r_seq_err    <= 1'b0;
`endif
        end else if (en) begin
            r_state      <= ST_COLLECT;
            r_beat_cnt   <= '0;
            r_tready     <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_num   <= 8'd0;
            r_len_err    <= 1'b0;
`ifdef DATA_UNPACK_SEQ_CHECK_EN
            r_seq_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    r_tready <= 1'b1;
                    if (w_hs) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt <= '0;
                            if (bus.s_axis_h2c_tlast) begin
                                r_state      <= ST_HOLD;
                                r_tready     <= 1'b0;
                                r_data_valid <= 1'b1;
                                r_in_io_data <= w_frame[4071:8];
                                r_data_num   <= w_seq + 8'd1;
`ifdef DATA_UNPACK_SEQ_CHECK_EN
                                if (w_seq != r_data_num) begin
                                    r_seq_err <= 1'b1;
                                end
`endif
                            end else begin
                                r_len_err <= 1'b1;
                                r_state   <= ST_DRAIN;
                            end
                        end else if (bus.s_axis_h2c_tlast) begin
                            r_len_err  <= 1'b1;
                            r_beat_cnt <= '0;
                        end else begin
                            for (int k = 0; k < FRAME_BEATS - 1; k++) begin
                                if (r_beat_cnt == CNT_W'(k)) begin
                                    r_buf[k*TDATA_W +: TDATA_W] <= bus.s_axis_h2c_tdata;
                                end
                            end
                            r_beat_cnt <= r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    r_tready <= 1'b1;
                    if (w_hs && bus.s_axis_h2c_tlast) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_HOLD: begin
                    if (bus.data_taken && r_data_valid) begin
                        r_data_valid <= 1'b0;
                        r_beat_cnt   <= '0;
                        r_tready     <= 1'b1;
                        r_state      <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state    <= ST_COLLECT;
                    r_beat_cnt <= '0;
                    r_tready   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/data_unpack.md
DATA_UNPACK -- requirements
Module: data_unpack

Interface
REQ-001 The block SHALL have parameter TDATA_W, default 512, H2C stream beat width in bits (power of two, 64..1024); FRAME_BEATS = ceil(4096/TDATA_W) is derived, not a parameter.
REQ-002 The block SHALL have port s_axis_h2c_aclk  in  1  sole clock, rising edge.
REQ-003 The block SHALL have port s_axis_h2c_aresetn  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port en  in  1  synchronous clear, high-active.
REQ-005 The block SHALL have port s_axis_h2c_tdata  in  TDATA_W  stream beat data.
REQ-006 The block SHALL have port s_axis_h2c_tvalid  in  1  beat valid.
REQ-007 The block SHALL have port s_axis_h2c_tlast  in  1  last beat of frame.
REQ-008 The block SHALL have port s_axis_h2c_tready  out  1  beat accept.
REQ-009 The block SHALL have port in_io_data  out  4064  unpacked frame payload.
REQ-010 The block SHALL have port data_valid  out  1  payload valid, held until taken.
REQ-011 The block SHALL have port data_taken  in  1  consumer acknowledge.
REQ-012 The block SHALL have port data_num_wire  out  8  expected next sequence number.
REQ-013 The block SHALL have port seq_err  out  1  sticky sequence-mismatch flag.
REQ-014 The block SHALL have port len_err  out  1  sticky frame-length-error flag.

Function
REQ-015 Frame SHALL be 4096 bits assembled from FRAME_BEATS beats, beat k to bits [k*TDATA_W+TDATA_W-1 : k*TDATA_W]; bits[7:0] = sequence number, bits[4071:8] = payload, bits[4095:4072] ignored.
REQ-016 States SHALL be COLLECT, DRAIN, HOLD; beat handshake = tvalid && tready.
REQ-017 COLLECT: tready=1; each handshake stores the beat at beat_cnt and increments beat_cnt (width ceil(log2(FRAME_BEATS))).
REQ-018 Handshake with tlast=1 and beat_cnt<FRAME_BEATS-1 SHALL set len_err, discard frame, clear beat_cnt, remain COLLECT.
REQ-019 Handshake at beat_cnt=FRAME_BEATS-1 with tlast=0 SHALL set len_err, discard frame, clear beat_cnt, go DRAIN.
REQ-020 DRAIN: tready=1, beats discarded; handshake with tlast=1 returns to COLLECT.
REQ-021 Handshake at beat_cnt=FRAME_BEATS-1 with tlast=1 SHALL go HOLD; next cycle data_valid=1 and in_io_data=bits[4071:8] (latency 1 cycle from final beat).
REQ-022 On frame completion data_num_wire SHALL become received sequence number +1, mod 256 (255 wraps to 0).
REQ-023 HOLD: tready=0; data_valid and in_io_data held stable until data_taken=1, then data_valid=0 next cycle, clear beat_cnt, go COLLECT.
REQ-024 data_taken while data_valid=0 SHALL be ignored.
REQ-025 seq_err and len_err SHALL stay 1 until reset or en.
REQ-026 en=1 SHALL override all other inputs: tready=0, data_valid=0, beat_cnt=0, data_num_wire=0, seq_err=0, len_err=0, state COLLECT, partial frame discarded.

Reset
REQ-027 On s_axis_h2c_aresetn=0, immediately: state COLLECT, beat_cnt=0, tready=0, data_valid=0, in_io_data=0, data_num_wire=0, seq_err=0, len_err=0.
REQ-028 tready SHALL rise no earlier than the first clock edge after reset deassertion; reset mid-frame or in HOLD discards the frame.

Configuration
REQ-029 With DATA_UNPACK_SEQ_CHECK_EN defined, a completed frame whose sequence number differs from data_num_wire SHALL set seq_err; frame is still delivered.
REQ-030 Without DATA_UNPACK_SEQ_CHECK_EN, seq_err SHALL be constant 0 and no comparator implemented; REQ-022 still applies.

Verification
REQ-031 Reset, 8 beats (TDATA_W=512) seq 0x00, payload pattern, tlast on beat 7 -> data_valid 1 cycle after beat 7, in_io_data = pattern, data_num_wire=0x01, tready=0 until data_taken.
REQ-032 Frames seq 0xFE, 0xFF, 0x00 back-to-back with immediate data_taken -> three deliveries, data_num_wire 0xFF, 0x00, 0x01, seq_err=0 (first frame after reset with seq 0xFE sets seq_err when macro defined).
REQ-033 Seq 0x00 then 0x05, macro defined -> seq_err=1 after second frame, payload delivered, data_num_wire=0x06; macro undefined -> seq_err=0.
REQ-034 tlast on beat 3 -> len_err=1, no data_valid; next correct 8-beat frame delivered normally.
REQ-035 10-beat frame, tlast on beat 9 -> len_err=1, beats 8-9 drained, no data_valid; following frame delivered.
REQ-036 en=1 during HOLD and asynchronous reset after beat 4 -> data_valid=0, errors cleared, data_num_wire=0, next full frame delivered.
